uart_receiver_counter: RTL and testbench

//  Bit-timing generator for the UART receive path. The parent receiver holds
//  i_rst high while the line is idle and releases it on the start-bit falling

---
 rtl/uart_receiver_counter_if.sv | 19 +
 rtl/uart_receiver_counter.sv | 91 +++++++++
 tb/tb_uart_receiver_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_counter_if.sv
// Bundle between the UART receiver and its bit-timing generator: baud divisor in,
// per-bit sample strobe and end-of-frame strobe out.
interface uart_receiver_counter_if;
    logic [15:0] receive_count_value;
    logic        receive_enable;
    logic        receive_finish;

    modport master (
        output receive_count_value,
        input  receive_enable,
        input  receive_finish
    );

    modport slave (
        input  receive_count_value,
        output receive_enable,
        output receive_finish
    );
endinterface

// File: rtl/uart_receiver_counter.sv
// UART receive bit-timing generator: after reset release, strobes enable at the
// centre of every frame bit and finish at the final stop-bit sample.
module uart_receiver_counter #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                    i_sys_clk,
    input  logic                    i_rst,
    uart_receiver_counter_if.slave  bus
);
    localparam int         FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam logic [3:0] FB_IDX     = 4'(FRAME_BITS);

    localparam logic [1:0] ST_HALF = 2'd0;
    localparam logic [1:0] ST_BIT  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [15:0] n_q;
    logic [15:0] n_load;
    logic [15:0] half_val;
    logic        enable_q, enable_d;
    logic        finish_q, finish_d;

    // Divisors below 2 would give a zero-length half bit; clamp them to 2.
    assign n_load   = (bus.receive_count_value < 16'd2) ? 16'd2 : bus.receive_count_value;
    assign half_val = n_q >> 1;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        enable_d  = 1'b0;
        finish_d  = 1'b0;
        case (state_q)
            ST_HALF: begin
                if (count_q == half_val - 16'd1) begin
                    enable_d  = 1'b1;
                    bit_idx_d = 4'd1;
                    count_d   = 16'd0;
                    state_d   = ST_BIT;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            ST_BIT: begin
                if (count_q == n_q - 16'd1) begin
                    enable_d  = 1'b1;
                    count_d   = 16'd0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q + 4'd1 == FB_IDX) begin
                        finish_d = 1'b1;
                        state_d  = ST_DONE;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // The divisor is captured only while reset is held, so it is frozen per frame.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q   <= ST_HALF;
            count_q   <= 16'd0;
            bit_idx_q <= 4'd0;
            enable_q  <= 1'b0;
            finish_q  <= 1'b0;
            n_q       <= n_load;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            enable_q  <= enable_d;
            finish_q  <= finish_d;
        end
    end

    assign bus.receive_enable = enable_q;
    assign bus.receive_finish = finish_q;
endmodule

// File: tb/tb_uart_receiver_counter.sv
// Scoreboard bench for uart_receiver_counter: 8N1 instance plus a 7-bit/parity/2-stop
// instance; expected strobe cycles are queued by stimulus and popped by a monitor.
module tb_uart_receiver_counter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    uart_receiver_counter_if ifa ();
    uart_receiver_counter_if ifb ();

    uart_receiver_counter #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .i_sys_clk (clk),
        .i_rst     (rst_a),
        .bus       (ifa.slave)
    );

    uart_receiver_counter #(.DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .i_sys_clk (clk),
        .i_rst     (rst_b),
        .bus       (ifb.slave)
    );

    typedef struct {
        int id;
        int cyc;
        bit fin;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: cycle 0 is the first cycle with reset low; sampled on the falling edge.
    logic [1:0] en_w, fin_w, rst_w;
    assign en_w  = {ifb.receive_enable, ifa.receive_enable};
    assign fin_w = {ifb.receive_finish, ifa.receive_finish};
    assign rst_w = {rst_b, rst_a};

    int cyc_cnt [2] = '{-1, -1};
    bit prev_rst[2] = '{1'b0, 1'b0};
    bit prev_en [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (prev_rst[k]) begin
                check($sformatf("reset_enable_dut%0d", k), int'(en_w[k]), 0);
                check($sformatf("reset_finish_dut%0d", k), int'(fin_w[k]), 0);
            end
            if (rst_w[k]) cyc_cnt[k] = -1;
            else          cyc_cnt[k] = cyc_cnt[k] + 1;
            if (fin_w[k]) check($sformatf("finish_implies_enable_dut%0d", k), int'(en_w[k]), 1);
            if (en_w[k])  check($sformatf("enable_back_to_back_dut%0d", k), int'(prev_en[k]), 0);
            if (en_w[k] || fin_w[k]) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: dut%0d strobe at cycle %0d, required none", k, cyc_cnt[k]);
                end else begin
                    e = sb_q.pop_front();
                    check("strobe_dut", k, e.id);
                    check($sformatf("strobe_cycle_dut%0d", k), cyc_cnt[k], e.cyc);
                    check($sformatf("strobe_finish_dut%0d", k), int'(fin_w[k]), int'(e.fin));
                end
            end
            prev_en[k]  = en_w[k];
            prev_rst[k] = rst_w[k];
        end
    end

    task automatic set_rst(input int id, input logic v);
        if (id == 0) rst_a = v;
        else         rst_b = v;
    endtask

    task automatic set_val(input int id, input int v);
        if (id == 0) ifa.receive_count_value = 16'(v);
        else         ifb.receive_count_value = 16'(v);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset with the given divisor, queue the hand-computed strobe cycles, release.
    task automatic frame(input int id, input int nval, input int hold,
                         input int first, input int step, input int cnt, input bit fin_last);
        exp_t e;
        set_rst(id, 1'b1);
        set_val(id, nval);
        run(hold);
        for (int j = 0; j < cnt; j++) begin
            e.id  = id;
            e.cyc = first + j * step;
            e.fin = fin_last && (j == cnt - 1);
            sb_q.push_back(e);
        end
        set_rst(id, 1'b0);
    endtask

    task automatic drained(input string name);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.receive_count_value = 16'd16;
        ifb.receive_count_value = 16'd8;
        run(3);
        check("reset_state_enable", int'(ifa.receive_enable), 0);
        check("reset_state_finish", int'(ifa.receive_finish), 0);

        // 8N1, N=16: 8,24,...,152
        frame(0, 16, 3, 8, 16, 10, 1'b1);
        run(170);
        drained("drain_n16");

        // N=5: 2,7,...,47
        frame(0, 5, 2, 2, 5, 10, 1'b1);
        run(60);
        drained("drain_n5");

        // N=0 and N=1 clamp to 2: 1,3,...,19
        frame(0, 0, 2, 1, 2, 10, 1'b1);
        run(30);
        drained("drain_n0");
        frame(0, 1, 2, 1, 2, 10, 1'b1);
        run(30);
        drained("drain_n1");

        // N=65535: first strobe at 32767
        frame(0, 65535, 2, 32767, 65535, 1, 1'b0);
        run(32800);
        drained("drain_n65535_first");

        // Reset at cycle 60 for 2 cycles, then a full restart
        frame(0, 16, 2, 8, 16, 4, 1'b0);
        run(60);
        frame(0, 16, 2, 8, 16, 10, 1'b1);
        run(170);
        drained("drain_midframe_reset");

        // Reset in the cycle that would launch the cycle-24 strobe: reset wins
        frame(0, 16, 2, 8, 16, 1, 1'b0);
        run(23);
        frame(0, 16, 1, 8, 16, 10, 1'b1);
        run(170);
        drained("drain_reset_wins");

        // Divisor change mid-frame is ignored; next frame uses N=4
        frame(0, 16, 2, 8, 16, 10, 1'b1);
        run(30);
        set_val(0, 4);
        run(140);
        drained("drain_n_change_ignored");
        frame(0, 4, 2, 2, 4, 10, 1'b1);
        run(50);
        drained("drain_n4");
        set_rst(0, 1'b1);
        run(2);

        // 7 data, parity, 2 stop, N=8: 11 strobes at 4,12,...,84
        frame(1, 8, 3, 4, 8, 11, 1'b1);
        run(100);
        drained("drain_7e2");
        set_rst(1, 1'b1);
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
